// File: rtl/wb_store_sequencer.sv
// In-order retired-store buffer feeding the dcache write port: stalls writeback when full
// and flags younger loads that hit the 8-byte block of any pending or in-flight store.
module wb_store_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enq_v,
  input  logic [AW-1:0]          enq_addr,
  input  logic [DW-1:0]          enq_data,
  input  logic [1:0]             enq_size,
  output logic                   sb_full,
  output logic                   sb_empty,
  output logic [$clog2(DEPTH):0] sb_count,
  output logic                   dc_wr_req,
  output logic [AW-1:0]          dc_wr_addr,
  output logic [DW-1:0]          dc_wr_data,
  output logic [1:0]             dc_wr_size,
  input  logic                   dc_wr_ready,
  input  logic                   dc_wr_done,
  input  logic                   ld_check_v,
  input  logic [AW-1:0]          ld_check_addr,
  output logic                   sb_ld_conflict
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_WAIT = 2'b10;

  logic [1:0]       state_r, state_nxt_s;
  logic [PW-1:0]    head_r, tail_r;
  logic [CW-1:0]    count_r, count_nxt_s;
  logic [DEPTH-1:0] valid_r;
  logic [AW-1:0]    addr_r [DEPTH];
  logic [DW-1:0]    data_r [DEPTH];
  logic [1:0]       size_r [DEPTH];
  logic             enq_acc_s, pop_s, conflict_s;
  logic             unused_ld_lsb_s;

  function automatic logic same_block(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return a[AW-1:3] == b[AW-1:3];
  endfunction

  // Full is judged on the registered count, so a same-cycle pop never frees a slot for enqueue.
  always_comb begin
    enq_acc_s   = enq_v && !sb_full;
    pop_s       = (state_r == S_WAIT) && dc_wr_done;
    count_nxt_s = count_r;
    case ({enq_acc_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Drain FSM; the head entry stays valid through WAIT so loads still see it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (count_r != {CW{1'b0}}) state_nxt_s = S_REQ;
        else                       state_nxt_s = S_IDLE;
      end
      S_REQ: begin
        if (dc_wr_ready) state_nxt_s = S_WAIT;
        else             state_nxt_s = S_REQ;
      end
      S_WAIT: begin
        if (pop_s) begin
          if (count_nxt_s != {CW{1'b0}}) state_nxt_s = S_REQ;
          else                           state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Control state: FSM, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      if (enq_acc_s) tail_r <= tail_r + PW'(1);
      if (pop_s)     head_r <= head_r + PW'(1);
    end
  end

  // Entry storage; head==tail with both pop and enqueue cannot occur (empty or full).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= {AW{1'b0}};
        data_r[i] <= {DW{1'b0}};
        size_r[i] <= 2'b00;
      end
    end else begin
      if (pop_s) valid_r[head_r] <= 1'b0;
      if (enq_acc_s) begin
        valid_r[tail_r] <= 1'b1;
        addr_r[tail_r]  <= enq_addr;
        data_r[tail_r]  <= enq_data;
        size_r[tail_r]  <= enq_size;
      end
    end
  end

  assign sb_full   = (count_r == CW'(DEPTH));
  assign sb_empty  = (count_r == {CW{1'b0}}) && (state_r == S_IDLE);
  assign sb_count  = count_r;
  assign dc_wr_req = (state_r == S_REQ);

  // Head fields read as zero when the head slot holds nothing.
  always_comb begin
    if (valid_r[head_r]) begin
      dc_wr_addr = addr_r[head_r];
      dc_wr_data = data_r[head_r];
      dc_wr_size = size_r[head_r];
    end else begin
      dc_wr_addr = {AW{1'b0}};
      dc_wr_data = {DW{1'b0}};
      dc_wr_size = 2'b00;
    end
  end

  // Block-granular match against every valid entry; size is deliberately ignored.
  always_comb begin
    conflict_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_r[i] && same_block(addr_r[i], ld_check_addr)) conflict_s = 1'b1;
      else                                                    conflict_s = conflict_s;
    end
  end

  assign sb_ld_conflict  = ld_check_v && conflict_s;
  assign unused_ld_lsb_s = ^ld_check_addr[2:0];

endmodule

// File: tb/tb_wb_store_sequencer.sv
// Scoreboard bench for wb_store_sequencer: expected stores queued at acceptance,
// compared when the dcache request is presented and accepted.
module tb_wb_store_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enq_v;
  logic [31:0] enq_addr;
  logic [63:0] enq_data;
  logic [1:0]  enq_size;
  logic        sb_full, sb_empty;
  logic [2:0]  sb_count;
  logic        dc_wr_req;
  logic [31:0] dc_wr_addr;
  logic [63:0] dc_wr_data;
  logic [1:0]  dc_wr_size;
  logic        dc_wr_ready, dc_wr_done;
  logic        ld_check_v;
  logic [31:0] ld_check_addr;
  logic        sb_ld_conflict;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
  } store_t;

  store_t exp_q[$];
  int total = 0;
  int bad = 0;
  int issued = 0;
  int issued_mark;

  wb_store_sequencer #(.DEPTH(4), .AW(32), .DW(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .enq_v(enq_v), .enq_addr(enq_addr), .enq_data(enq_data), .enq_size(enq_size),
    .sb_full(sb_full), .sb_empty(sb_empty), .sb_count(sb_count),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .dc_wr_size(dc_wr_size), .dc_wr_ready(dc_wr_ready), .dc_wr_done(dc_wr_done),
    .ld_check_v(ld_check_v), .ld_check_addr(ld_check_addr), .sb_ld_conflict(sb_ld_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
    enq_v    = 1'b1;
    enq_addr = a;
    enq_data = d;
    enq_size = s;
  endtask

  // Scoreboard: compare presented head against oldest expected store; push accepted stores.
  always @(negedge clk) begin
    store_t head;
    if (rst_n) begin
      if (dc_wr_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", 64'd1, 64'd0);
        end else begin
          head = exp_q[0];
          check("wr_addr", {32'd0, dc_wr_addr}, {32'd0, head.addr});
          check("wr_data", dc_wr_data, head.data);
          check("wr_size", {62'd0, dc_wr_size}, {62'd0, head.size});
          if (dc_wr_ready) begin
            head = exp_q.pop_front();
            issued++;
          end
        end
      end
      if (enq_v && !sb_full) exp_q.push_back({enq_addr, enq_data, enq_size});
    end
  end

  initial begin
    rst_n = 1'b0; enq_v = 1'b0; enq_addr = 32'd0; enq_data = 64'd0; enq_size = 2'b00;
    dc_wr_ready = 1'b0; dc_wr_done = 1'b0; ld_check_v = 1'b1; ld_check_addr = 32'd0;
    repeat (3) tick();
    check("rst_full", {63'd0, sb_full}, 64'd0);
    check("rst_empty", {63'd0, sb_empty}, 64'd1);
    check("rst_count", {61'd0, sb_count}, 64'd0);
    check("rst_req", {63'd0, dc_wr_req}, 64'd0);
    check("rst_addr", {32'd0, dc_wr_addr}, 64'd0);
    check("rst_conflict", {63'd0, sb_ld_conflict}, 64'd0);
    ld_check_v = 1'b0;
    rst_n = 1'b1;
    tick();

    // reset while the head store is in WAIT with three entries held
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h0000_0100 + 32'(i * 8), 64'hC0DE_0000_0000_0000 + 64'(i), 2'b11);
      tick();
    end
    enq_v = 1'b0;
    dc_wr_ready = 1'b1;
    tick();
    dc_wr_ready = 1'b0;
    check("t1_count_wait", {61'd0, sb_count}, 64'd3);
    check("t1_req_wait", {63'd0, dc_wr_req}, 64'd0);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t1_count_rst", {61'd0, sb_count}, 64'd0);
    check("t1_empty_rst", {63'd0, sb_empty}, 64'd1);
    check("t1_req_rst", {63'd0, dc_wr_req}, 64'd0);
    tick();
    rst_n = 1'b1;
    dc_wr_done = 1'b1;
    tick();
    dc_wr_done = 1'b0;
    check("t1_count_done", {61'd0, sb_count}, 64'd0);
    check("t1_empty_done", {63'd0, sb_empty}, 64'd1);
    check("t1_req_done", {63'd0, dc_wr_req}, 64'd0);

    // single store with zero-wait READY/DONE
    drive_store(32'h0000_1000, 64'h0000_0000_1122_3344, 2'b10);
    dc_wr_ready = 1'b1;
    dc_wr_done  = 1'b1;
    tick();
    enq_v = 1'b0;
    check("t2_req_n", {63'd0, dc_wr_req}, 64'd0);
    check("t2_count_n", {61'd0, sb_count}, 64'd1);
    tick();
    check("t2_req_n1", {63'd0, dc_wr_req}, 64'd1);
    check("t2_addr_n1", {32'd0, dc_wr_addr}, 64'h1000);
    check("t2_size_n1", {62'd0, dc_wr_size}, 64'd2);
    tick();
    check("t2_req_n2", {63'd0, dc_wr_req}, 64'd0);
    check("t2_empty_n2", {63'd0, sb_empty}, 64'd0);
    tick();
    check("t2_empty_n3", {63'd0, sb_empty}, 64'd1);
    check("t2_count_n3", {61'd0, sb_count}, 64'd0);
    dc_wr_ready = 1'b0;
    dc_wr_done  = 1'b0;

    // fill, hold a fifth store, same-edge DONE and rejected enqueue, then drain in order
    issued_mark = issued;
    for (int i = 0; i < 4; i++) begin
      drive_store(32'h0000_3000 + 32'(i * 8), 64'hA5A5_0000_0000_0000 + 64'(i), 2'(i));
      tick();
    end
    check("t3_full", {63'd0, sb_full}, 64'd1);
    check("t3_count4", {61'd0, sb_count}, 64'd4);
    drive_store(32'h0000_3020, 64'hA5A5_0000_0000_0004, 2'b00);
    tick();
    tick();
    check("t3_count_held", {61'd0, sb_count}, 64'd4);
    dc_wr_ready = 1'b1;
    tick();
    dc_wr_ready = 1'b0;
    dc_wr_done  = 1'b1;
    tick();
    dc_wr_done  = 1'b0;
    check("t6_count_pop", {61'd0, sb_count}, 64'd3);
    check("t6_full_pop", {63'd0, sb_full}, 64'd0);
    check("t6_req_pop", {63'd0, dc_wr_req}, 64'd1);
    tick();
    enq_v = 1'b0;
    check("t6_count_acc", {61'd0, sb_count}, 64'd4);
    dc_wr_ready = 1'b1;
    dc_wr_done  = 1'b1;
    for (int i = 0; i < 40 && !sb_empty; i++) tick();
    dc_wr_ready = 1'b0;
    dc_wr_done  = 1'b0;
    check("t3_drain_empty", {63'd0, sb_empty}, 64'd1);
    check("t3_issued", 64'(issued - issued_mark), 64'd5);
    check("t3_queue_left", 64'(exp_q.size()), 64'd0);

    // late READY and DONE: fields held by the scoreboard checks, one pop
    issued_mark = issued;
    drive_store(32'h0000_4448, 64'hDEAD_BEEF_0BAD_F00D, 2'b01);
    tick();
    enq_v = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("t4_req_stall", {63'd0, dc_wr_req}, 64'd1);
    dc_wr_ready = 1'b1;
    tick();
    dc_wr_ready = 1'b0;
    tick();
    tick();
    check("t4_count_wait", {61'd0, sb_count}, 64'd1);
    check("t4_req_wait", {63'd0, dc_wr_req}, 64'd0);
    dc_wr_done = 1'b1;
    tick();
    dc_wr_done = 1'b0;
    check("t4_count_pop", {61'd0, sb_count}, 64'd0);
    check("t4_empty_pop", {63'd0, sb_empty}, 64'd1);
    check("t4_issued", 64'(issued - issued_mark), 64'd1);
    dc_wr_done = 1'b1;
    tick();
    dc_wr_done = 1'b0;
    check("t4_stray_done", {61'd0, sb_count}, 64'd0);

    // load conflict against pending and in-flight store
    drive_store(32'h0000_2004, 64'h0000_0000_5566_7788, 2'b10);
    tick();
    enq_v = 1'b0;
    ld_check_v = 1'b1; ld_check_addr = 32'h0000_2000;
    #1 check("t5_hit_2000", {63'd0, sb_ld_conflict}, 64'd1);
    ld_check_addr = 32'h0000_2008;
    #1 check("t5_miss_2008", {63'd0, sb_ld_conflict}, 64'd0);
    ld_check_v = 1'b0; ld_check_addr = 32'h0000_2000;
    #1 check("t5_no_probe", {63'd0, sb_ld_conflict}, 64'd0);
    tick();
    dc_wr_ready = 1'b1;
    tick();
    dc_wr_ready = 1'b0;
    ld_check_v = 1'b1; ld_check_addr = 32'h0000_2007;
    #1 check("t5_hit_inflight", {63'd0, sb_ld_conflict}, 64'd1);
    dc_wr_done = 1'b1;
    tick();
    dc_wr_done = 1'b0;
    ld_check_addr = 32'h0000_2000;
    #1 check("t5_after_done", {63'd0, sb_ld_conflict}, 64'd0);
    ld_check_v = 1'b0;
    tick();
    check("end_queue_left", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
